// File: rtl/fir_out_capture.sv
// fir_out_capture: output-side receiver for the W4823 FIR core.
// Captures the raw FP29i accumulator word once per rising edge of the FIR
// valid level. Stage A normalizes the word and stage B rounds and packs it
// to IEEE FP16. Results are buffered in a small FIFO that is drained
// through a ready/valid handshake.
// Optional feature macro: FIR_OUT_ROUND_EN (round-to-nearest-even when
// defined, truncation when undefined).
module fir_out_capture #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fir_valid,
    input  logic [28:0]                   fir_dout_29i,
    output logic [15:0]                   out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          ovf_flag,
    input  logic                          ovf_clr,
    output logic [CNT_W-1:0]              sample_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    // ------------------------------------------------------------------
    // Capture: edge detect on the FIR valid level
    // ------------------------------------------------------------------
    logic             vld_q_reg;
    logic             capture;
    logic [CNT_W-1:0] cnt_reg;

    assign capture = fir_valid & ~vld_q_reg;

    // vld_q resets high so a level already high at reset release is ignored
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q_reg <= 1'b1;
        end else begin
            vld_q_reg <= fir_valid;
        end
    end

    // Captured-sample counter, wraps naturally
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_reg <= '0;
        end else if (capture) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
        end
    end

    assign sample_cnt = cnt_reg;

    // ------------------------------------------------------------------
    // Stage A: normalize the incoming mantissa
    // ------------------------------------------------------------------
    logic               in_sign;
    logic [5:0]         in_exp;
    logic [21:0]        in_mant;
    logic [4:0]         lz_next;
    logic [21:0]        m_norm;
    logic signed [6:0]  e_norm;
    logic               unused_norm;

    assign in_sign = fir_dout_29i[28];
    assign in_exp  = fir_dout_29i[27:22];
    assign in_mant = fir_dout_29i[21:0];

    // Leading-zero count: the highest set bit wins; m==0 is flagged separately
    always_comb begin
        lz_next = 5'd21;
        for (int i = 0; i < 22; i++) begin
            if (in_mant[i]) begin
                lz_next = 5'(21 - i);
            end
        end
    end

    assign m_norm = in_mant << lz_next;
    assign e_norm = $signed({1'b0, in_exp}) - $signed({2'b00, lz_next});

    logic               a_valid_reg;
    logic               a_sign_reg;
    logic               a_zero_reg;
    logic signed [6:0]  a_exp_reg;
    logic [9:0]         a_frac_reg;
`ifdef FIR_OUT_ROUND_EN
    logic               a_guard_reg;
    logic               a_sticky_reg;

    // The hidden bit m_norm[21] is implied by normalization
    assign unused_norm = m_norm[21];

    // Guard and sticky are only kept when rounding is enabled
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_guard_reg  <= 1'b0;
            a_sticky_reg <= 1'b0;
        end else if (capture) begin
            a_guard_reg  <= m_norm[10];
            a_sticky_reg <= |m_norm[9:0];
        end
    end
`else
    // Truncation discards everything below the FP16 fraction
    assign unused_norm = ^{m_norm[21], m_norm[10:0]};
`endif

    // Stage A register: loads on the capture clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_valid_reg <= 1'b0;
            a_sign_reg  <= 1'b0;
            a_zero_reg  <= 1'b0;
            a_exp_reg   <= '0;
            a_frac_reg  <= '0;
        end else begin
            a_valid_reg <= capture;
            if (capture) begin
                a_sign_reg <= in_sign;
                a_zero_reg <= (in_mant == 22'd0);
                a_exp_reg  <= e_norm;
                a_frac_reg <= m_norm[20:11];
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage B: rebias, round, detect overflow/underflow, pack FP16
    // ------------------------------------------------------------------
    logic signed [7:0]  exp_b;
    logic signed [7:0]  exp_r;
    logic               round_up;
    logic [10:0]        frac_sum;
    logic [15:0]        result_next;

`ifdef FIR_OUT_ROUND_EN
    assign round_up = a_guard_reg & (a_sticky_reg | a_frac_reg[0]);
`else
    assign round_up = 1'b0;
`endif

    // FP29i bias 31 with mantissa scaled by 2^-21 maps to FP16 bias 15 as E = e' - 16
    always_comb begin
        exp_b       = $signed({a_exp_reg[6], a_exp_reg}) - 8'sd16;
        frac_sum    = {1'b0, a_frac_reg} + {10'd0, round_up};
        exp_r       = exp_b + $signed({7'd0, frac_sum[10]});
        result_next = {a_sign_reg, exp_r[4:0], frac_sum[9:0]};
        if (a_zero_reg || (exp_b <= 8'sd0)) begin
            // Rounding never lowers E, so checking before rounding covers both
            result_next = {a_sign_reg, 15'h0000};
        end else if (exp_r >= 8'sd31) begin
            result_next = {a_sign_reg, 5'h1F, 10'h000};
        end
    end

    logic        b_valid_reg;
    logic [15:0] b_data_reg;

    // Stage B register: packed result one clock after stage A
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_valid_reg <= 1'b0;
            b_data_reg  <= '0;
        end else begin
            b_valid_reg <= a_valid_reg;
            if (a_valid_reg) begin
                b_data_reg <= result_next;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output FIFO
    // ------------------------------------------------------------------
    logic [15:0]   mem_reg [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [LW-1:0] level_reg;
    logic          ovf_reg;
    logic          full;
    logic          rd_en;
    logic          wr_en;
    logic          wr_drop;

    assign full    = (level_reg == LW'(FIFO_DEPTH));
    assign rd_en   = out_valid & out_ready;
    assign wr_en   = b_valid_reg & (~full | rd_en);
    assign wr_drop = b_valid_reg & full & ~rd_en;

    // Storage array: no reset needed, unread entries are never exposed
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_ptr_reg] <= b_data_reg;
        end
    end

    // Pointers and occupancy; simultaneous read and write keeps the level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (rd_en) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            case ({wr_en, rd_en})
                2'b10:   level_reg <= level_reg + LW'(1);
                2'b01:   level_reg <= level_reg - LW'(1);
                default: level_reg <= level_reg;
            endcase
        end
    end

    // Sticky overflow flag; a drop wins over a simultaneous clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (wr_drop) begin
            ovf_reg <= 1'b1;
        end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
        end
    end

    assign out_valid  = (level_reg != '0);
    // Head is gated to zero when empty so the output is defined after reset
    assign out_data   = out_valid ? mem_reg[rd_ptr_reg] : 16'h0000;
    assign fifo_level = level_reg;
    assign ovf_flag   = ovf_reg;

endmodule
